// File: rtl/uart_tx_feeder.sv
// Byte FIFO + sequencer feeding a UART transmitter one byte per frame.
// Latency: write at edge N -> o_tx_dv pulse after edge N+1; next byte pulses the cycle after i_tx_done.
// Backpressure: none upstream; writes while full are dropped and flagged on o_overflow for one cycle.
module uart_tx_feeder #(
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [7:0]                 i_wr_byte,
  input  logic                       i_wr_dv,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow,
  output logic                       o_busy,
  output logic [7:0]                 o_tx_byte,
  output logic                       o_tx_dv,
  input  logic                       i_tx_active,
  input  logic                       i_tx_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;

  logic wr_acc;
  logic pop;

  // Full/empty are judged on the registered count, so a write against a full
  // FIFO is dropped even when a pop frees a slot on the same edge.
  assign wr_acc = i_wr_dv && !o_full;

  // Idle issues only into a quiet transmitter; wait issues only on its done pulse.
  assign pop = (count != '0) &&
               (((state == ST_IDLE) && !i_tx_active) ||
                ((state == ST_WAIT) && i_tx_done));

  assign o_full  = (count == FULL_CNT);
  assign o_empty = (count == '0);
  assign o_count = count;
  assign o_busy  = (state != ST_IDLE) || (count != '0);

  // Storage array; contents need no reset since reads are gated by count.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= i_wr_byte;
    end
  end

  // Pointers, occupancy count and the dropped-write flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= i_wr_dv && o_full;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_acc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Handshake sequencer: one data-valid pulse per byte, then hold until done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      o_tx_dv   <= 1'b0;
      o_tx_byte <= 8'h00;
    end else begin
      o_tx_dv <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            o_tx_byte <= mem[rd_ptr];
            o_tx_dv   <= 1'b1;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_tx_done) begin
            if (pop) begin
              o_tx_byte <= mem[rd_ptr];
              o_tx_dv   <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench for uart_tx_feeder with a queue-based reference model
// and a stub transmitter whose frame timing is driven from the model.
module tb_uart_tx_feeder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_wr_byte;
  logic       i_wr_dv;
  logic       o_full;
  logic       o_empty;
  logic [2:0] o_count;
  logic       o_overflow;
  logic       o_busy;
  logic [7:0] o_tx_byte;
  logic       o_tx_dv;
  logic       i_tx_active;
  logic       i_tx_done;

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wr_byte   (i_wr_byte),
    .i_wr_dv     (i_wr_dv),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .o_busy      (o_busy),
    .o_tx_byte   (o_tx_byte),
    .o_tx_dv     (o_tx_dv),
    .i_tx_active (i_tx_active),
    .i_tx_done   (i_tx_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: buffered bytes, byte-in-flight flag, last issued byte
  logic [7:0] q[$];
  bit         inflight = 0;
  logic [7:0] m_byte   = 8'h00;
  bit         m_dv     = 0;
  bit         m_ovf    = 0;

  // transmitter stub controls
  int stub_left    = 0;
  int flen         = 40;
  bit hold         = 0;
  bit force_active = 0;
  int spur_pct     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("tx_dv",    32'(o_tx_dv),    32'(m_dv));
    chk("tx_byte",  32'(o_tx_byte),  32'(m_byte));
    chk("count",    32'(o_count),    32'(q.size()));
    chk("full",     32'(o_full),     32'(q.size() == DEPTH));
    chk("empty",    32'(o_empty),    32'(q.size() == 0));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
    chk("busy",     32'(o_busy),     32'(inflight || (q.size() != 0)));
  endtask

  task automatic model_reset();
    q.delete();
    inflight  = 0;
    m_byte    = 8'h00;
    m_dv      = 0;
    m_ovf     = 0;
    stub_left = 0;
  endtask

  // one clock: drive inputs, predict the edge, then check after it
  task automatic cyc(input bit wr, input logic [7:0] b);
    bit act, dn, full_pre, pop, spur;
    spur = ($urandom_range(99) < spur_pct);
    act  = force_active || (stub_left > 0);
    dn   = ((stub_left == 1) && !hold) || ((stub_left == 0) && spur);
    i_wr_dv     = wr;
    i_wr_byte   = b;
    i_tx_active = act;
    i_tx_done   = dn;
    full_pre = (q.size() == DEPTH);
    m_ovf    = wr && full_pre;
    pop      = (q.size() > 0) && (inflight ? dn : !act);
    if (pop) begin
      m_byte   = q.pop_front();
      m_dv     = 1;
      inflight = 1;
    end else begin
      m_dv = 0;
      if (inflight && dn) inflight = 0;
    end
    if (wr && !full_pre) q.push_back(b);
    @(posedge clk);
    #1;
    if (dn && (stub_left == 1)) stub_left = 0;
    else if (stub_left > 1) stub_left--;
    if (m_dv) stub_left = flen;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  initial begin
    rst_n       = 1'b0;
    i_wr_dv     = 1'b0;
    i_wr_byte   = 8'h00;
    i_tx_active = 1'b0;
    i_tx_done   = 1'b0;
    model_reset();
    #12;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single byte through a full-length frame
    flen = 40;
    cyc(1'b1, 8'hA5);
    idle(50);

    // burst of four
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i));
    idle(4 * 42 + 10);

    // six back-to-back: one in flight, four buffered, sixth dropped
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h10 + i));
    idle(5 * 42 + 10);

    // full FIFO, write coincident with the pop edge
    flen = 3;
    hold = 1;
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h20 + i));
    idle(3);
    hold = 0;
    cyc(1'b1, 8'hEE);
    idle(30);

    // asynchronous reset in the middle of frame 2 of 3
    flen = 40;
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h30 + i));
    idle(60);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    force_active = 1;
    cyc(1'b1, 8'h5A);
    idle(20);
    force_active = 0;
    idle(50);

    // long stall waiting on done
    flen = 3;
    hold = 1;
    cyc(1'b1, 8'hAA);
    cyc(1'b1, 8'hBB);
    cyc(1'b1, 8'hCC);
    idle(1000);
    hold = 0;
    cyc(1'b0, 8'h00);
    hold = 1;
    idle(5);
    hold = 0;
    idle(20);

    // randomized traffic
    spur_pct = 5;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 10) flen = $urandom_range(1, 8);
      if ($urandom_range(99) < 3) force_active = ~force_active;
      cyc($urandom_range(99) < 40, 8'($urandom));
    end
    force_active = 0;
    spur_pct     = 0;
    idle(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
